// File: rtl/multdiv_if.sv
// Operand/control/result bundle between the execute stage and multdiv_iter.
// master: execute stage issuing operations; slave: the multiply/divide unit.
interface multdiv_if;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    modport master (
        output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit multiply (radix-4 Booth) and divide (non-restoring).
// The divider is compiled in only when MULTDIV_DIV_EN is defined.
module multdiv_iter (
    input  logic     clock,
    input  logic     resetn,
    multdiv_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [33:0] acc_q, acc_d;
    logic [31:0] mq_q, mq_d;
    logic        qm1_q, qm1_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] res_q, res_d;
    logic        exc_q, exc_d;

    logic [2:0]  booth;
    logic [33:0] pp_sel;
    logic [33:0] pp;
    logic        pp_neg;
    logic [33:0] acc_sum;
    logic [33:0] acc_nx;
    logic [31:0] mq_nx;
    logic [63:0] prod;

    // Two guard bits on the accumulator absorb the +/-2M partial products.
    always_comb begin
        booth  = {mq_q[1:0], qm1_q};
        pp_neg = booth[2] & ~(booth[1] & booth[0]);
        unique case (booth)
            3'b001, 3'b010, 3'b101, 3'b110:
                pp_sel = {{2{mcand_q[31]}}, mcand_q};
            3'b011, 3'b100:
                pp_sel = {mcand_q[31], mcand_q, 1'b0};
            default:
                pp_sel = '0;
        endcase
        pp      = pp_neg ? ~pp_sel : pp_sel;
        acc_sum = acc_q + pp + {33'd0, pp_neg};
        acc_nx  = {{2{acc_sum[33]}}, acc_sum[33:2]};
        mq_nx   = {acc_sum[1:0], mq_q[31:2]};
        prod    = {acc_nx[31:0], mq_nx};
    end

`ifdef MULTDIV_DIV_EN
    logic [32:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        neg_q, neg_d;
    logic        ovf_q, ovf_d;

    logic [32:0] rem_sh;
    logic [32:0] rem_nx;
    logic [31:0] quo_nx;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    // Remainder sign selects add or subtract; quotient bit is its inverse.
    always_comb begin
        rem_sh = {rem_q[31:0], quo_q[31]};
        rem_nx = rem_q[32] ? rem_sh + {1'b0, dvsr_q}
                           : rem_sh - {1'b0, dvsr_q};
        quo_nx = {quo_q[30:0], ~rem_nx[32]};
        a_mag  = bus.data_operandA[31] ? -bus.data_operandA
                                       : bus.data_operandA;
        b_mag  = bus.data_operandB[31] ? -bus.data_operandB
                                       : bus.data_operandB;
    end
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        mq_d    = mq_q;
        qm1_d   = qm1_q;
        mcand_d = mcand_q;
        res_d   = res_q;
        exc_d   = exc_q;
`ifdef MULTDIV_DIV_EN
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvsr_d  = dvsr_q;
        neg_d   = neg_q;
        ovf_d   = ovf_q;
`endif
        if (bus.ctrl_MULT) begin
            state_d = S_MUL;
            cnt_d   = '0;
            acc_d   = '0;
            mq_d    = bus.data_operandB;
            qm1_d   = 1'b0;
            mcand_d = bus.data_operandA;
        end else if (bus.ctrl_DIV) begin
`ifdef MULTDIV_DIV_EN
            if (bus.data_operandB == '0) begin
                state_d = S_DONE;
                res_d   = '0;
                exc_d   = 1'b1;
            end else begin
                state_d = S_DIV;
                cnt_d   = '0;
                rem_d   = '0;
                quo_d   = a_mag;
                dvsr_d  = b_mag;
                neg_d   = bus.data_operandA[31] ^ bus.data_operandB[31];
                ovf_d   = (bus.data_operandA == 32'h8000_0000) &&
                          (bus.data_operandB == 32'hFFFF_FFFF);
            end
`else
            state_d = S_DONE;
            res_d   = '0;
            exc_d   = 1'b1;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: state_d = S_IDLE;
                S_MUL: begin
                    acc_d = acc_nx;
                    mq_d  = mq_nx;
                    qm1_d = mq_q[1];
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd15) begin
                        state_d = S_DONE;
                        res_d   = prod[31:0];
                        exc_d   = prod[63:32] != {32{prod[31]}};
                    end
                end
                S_DIV: begin
`ifdef MULTDIV_DIV_EN
                    rem_d = rem_nx;
                    quo_d = quo_nx;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d = S_DONE;
                        res_d   = neg_q ? -quo_nx : quo_nx;
                        exc_d   = ovf_q;
                    end
`else
                    state_d = S_IDLE;
`endif
                end
                S_DONE: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            qm1_q   <= 1'b0;
            mcand_q <= '0;
            res_q   <= '0;
            exc_q   <= 1'b0;
`ifdef MULTDIV_DIV_EN
            rem_q   <= '0;
            quo_q   <= '0;
            dvsr_q  <= '0;
            neg_q   <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mq_q    <= mq_d;
            qm1_q   <= qm1_d;
            mcand_q <= mcand_d;
            res_q   <= res_d;
            exc_q   <= exc_d;
`ifdef MULTDIV_DIV_EN
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvsr_q  <= dvsr_d;
            neg_q   <= neg_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.data_result    = res_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = (state_q == S_DONE);
    assign bus.busy           = (state_q == S_MUL) || (state_q == S_DIV);
endmodule
